// File: rtl/dmux_1x4_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer.
//   NUM_LANES : number of output lanes
//   SEL_W     : width of the lane select
//   onehot4() : converts a lane select into a one-hot lane vector
package dmux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    function automatic logic [NUM_LANES-1:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [NUM_LANES-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dmux_1x4_lane_reg.sv
// Single output-lane register of the demultiplexer.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the lane
//   i_we  : load i_d on the next edge
//   i_clr : when not loading, clear the lane (1) or keep it (0)
//   i_d   : lane data in
//   o_q   : registered lane value
module dmux_lane_reg #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end else if (i_clr) begin
            r_q <= '0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dmux_1x4.sv
// 1-to-4 demultiplexer with optional output registering.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, forces all outputs to 0
//   d        : data input
//   sel      : lane select, 0 -> lane0 ... 3 -> lane3
//   in_valid : qualifies d/sel; when low no lane is written
//   y        : output lanes, lane k at [k*DATA_W +: DATA_W]
//   y_valid  : one-hot per-lane valid strobe
// REG_OUT=1 registers the outputs (1 cycle latency); REG_OUT=0 is purely
// combinational. HOLD=1 makes unselected lanes keep their last value and
// is only meaningful with registered outputs.
module dmux_1x4
    import dmux_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter int REG_OUT = 1,
    parameter int HOLD    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             d,
    input  logic [SEL_W-1:0]              sel,
    input  logic                          in_valid,
    output logic [NUM_LANES*DATA_W-1:0]   y,
    output logic [NUM_LANES-1:0]          y_valid
);

    if (DATA_W < 1) begin : g_bad_width
        $error("dmux_1x4: DATA_W must be at least 1");
    end
    if (HOLD != 0 && REG_OUT == 0) begin : g_bad_hold
        $error("dmux_1x4: HOLD=1 requires REG_OUT=1");
    end

    logic [NUM_LANES-1:0] w_we;

    // Per-lane write strobe: the selected lane, only on a valid beat.
    assign w_we = onehot4(sel) & {NUM_LANES{in_valid}};

    if (REG_OUT != 0) begin : g_reg
        logic [NUM_LANES*DATA_W-1:0] w_q;
        logic [NUM_LANES-1:0]        r_y_valid;
        // Lanes clear themselves when not written unless holding.
        logic                        w_clr;

        assign w_clr = (HOLD == 0);

        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
            dmux_lane_reg #(.DATA_W(DATA_W)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .i_we  (w_we[k]),
                .i_clr (w_clr),
                .i_d   (d),
                .o_q   (w_q[k*DATA_W +: DATA_W])
            );
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_y_valid <= '0;
            end else begin
                r_y_valid <= w_we;
            end
        end

        assign y       = w_q;
        assign y_valid = r_y_valid;
    end else begin : g_comb
        // Clock has no role in the combinational variant.
        logic w_unused_clk;
        assign w_unused_clk = clk;

        // Reset still gates the outputs so they read 0 while rst_n is low.
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
            assign y[k*DATA_W +: DATA_W] = (w_we[k] && rst_n) ? d : '0;
        end
        assign y_valid = w_we & {NUM_LANES{rst_n}};
    end

endmodule

// File: tb/tb_dmux_1x4.sv
module tb_dmux_1x4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  d;
    logic [1:0]  sel;
    logic        vld;

    logic [3:0]  yA;  logic [3:0] yvA;   // DATA_W=1, REG_OUT=1, HOLD=0
    logic [31:0] yB;  logic [3:0] yvB;   // DATA_W=8, REG_OUT=1, HOLD=1
    logic [15:0] yC;  logic [3:0] yvC;   // DATA_W=4, REG_OUT=0

    dmux_1x4 #(.DATA_W(1), .REG_OUT(1), .HOLD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .d(d[0:0]), .sel(sel), .in_valid(vld),
        .y(yA), .y_valid(yvA));
    dmux_1x4 #(.DATA_W(8), .REG_OUT(1), .HOLD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .in_valid(vld),
        .y(yB), .y_valid(yvB));
    dmux_1x4 #(.DATA_W(4), .REG_OUT(0), .HOLD(0)) u_c (
        .clk(clk), .rst_n(rst_n), .d(d[3:0]), .sel(sel), .in_valid(vld),
        .y(yC), .y_valid(yvC));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: what each lane of the registered DUTs should show now.
    int unsigned mA[4];
    int unsigned mB[4];
    int unsigned mvA, mvB;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            mA[k] = 0;
            mB[k] = 0;
        end
        mvA = 0;
        mvB = 0;
    endtask

    // Apply one beat, let the clock capture it, update the model.
    task automatic step(input logic [7:0] dd, input logic [1:0] ss, input logic vv);
        d   = dd;
        sel = ss;
        vld = vv;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int k = 0; k < 4; k++)
                mA[k] = (vv && int'(ss) == k) ? int'(dd[0]) : 0;
            if (vv) mB[ss] = int'(dd);
            mvA = vv ? (1 << ss) : 0;
            mvB = mvA;
        end
        #1;
    endtask

    // Every cycle: compare all three DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0]  eA;
            logic [31:0] eB;
            logic [15:0] eC;
            logic [3:0]  evC;
            eA = '0; eB = '0; eC = '0; evC = '0;
            for (int k = 0; k < 4; k++) begin
                eA[k]        = mA[k][0];
                eB[k*8 +: 8] = mB[k][7:0];
            end
            if (rst_n && vld) begin
                eC[sel*4 +: 4] = d[3:0];
                evC            = 4'(1 << sel);
            end
            chk("cyc_yA",  64'(yA),  64'(eA));
            chk("cyc_yvA", 64'(yvA), 64'(mvA[3:0]));
            chk("cyc_yB",  64'(yB),  64'(eB));
            chk("cyc_yvB", 64'(yvB), 64'(mvB[3:0]));
            chk("cyc_yC",  64'(yC),  64'(eC));
            chk("cyc_yvC", 64'(yvC), 64'(evC));
        end
    end

    initial begin
        logic [3:0] exp_oh;
        d = '0; sel = '0; vld = 1'b0;
        rst_n = 1'b1;
        model_clear();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_yA", 64'(yA), 64'h0);
        chk("rst_yvA", 64'(yvA), 64'h0);
        chk("rst_yB", 64'(yB), 64'h0);
        chk("rst_yvB", 64'(yvB), 64'h0);
        chk("rst_yC", 64'(yC), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // d=1 sweep: one-hot data and valid one cycle later
        for (int s = 0; s < 4; s++) begin
            step(8'h01, 2'(s), 1'b1);
            exp_oh = 4'(1 << s);
            chk("sweep1_yA", 64'(yA), 64'(exp_oh));
            chk("sweep1_yvA", 64'(yvA), 64'(exp_oh));
        end

        // d=0 sweep: zero data but valid still flags the lane
        for (int s = 0; s < 4; s++) begin
            step(8'h00, 2'(s), 1'b1);
            exp_oh = 4'(1 << s);
            chk("sweep0_yA", 64'(yA), 64'h0);
            chk("sweep0_yvA", 64'(yvA), 64'(exp_oh));
        end

        // HOLD: two writes then idle, both lanes persist
        step(8'h00, 2'd0, 1'b0);
        step(8'hA5, 2'd1, 1'b1);
        step(8'h3C, 2'd3, 1'b1);
        chk("hold_wr_yB", 64'(yB), 64'h3C00_A500);
        chk("hold_wr_yvB", 64'(yvB), 64'h8);
        step(8'hFF, 2'd2, 1'b0);
        chk("hold_idle_yB", 64'(yB), 64'h3C00_A500);
        chk("hold_idle_yvB", 64'(yvB), 64'h0);

        // Asynchronous reset mid-cycle clears held lanes immediately
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_yB", 64'(yB), 64'h0);
        chk("async_rst_yvB", 64'(yvB), 64'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h00, 2'd1, 1'b0);
        chk("post_rst_yB", 64'(yB), 64'h0);
        step(8'h11, 2'd0, 1'b1);
        chk("post_rst_wr_yB", 64'(yB), 64'h0000_0011);
        chk("post_rst_wr_yvB", 64'(yvB), 64'h1);

        // Combinational variant: same-cycle response
        d = 8'h0F; sel = 2'd2; vld = 1'b1;
        #1;
        chk("comb_yC", 64'(yC), 64'h0F00);
        chk("comb_yvC", 64'(yvC), 64'h4);
        vld = 1'b0;
        #1;
        chk("comb_drop_yC", 64'(yC), 64'h0000);
        chk("comb_drop_yvC", 64'(yvC), 64'h0);
        step(8'h0F, 2'd2, 1'b0);

        // Idle with random select: nothing ever asserted (HOLD=0 DUT)
        for (int i = 0; i < 20; i++) begin
            step(8'($urandom), 2'($urandom_range(3)), 1'b0);
            chk("idle_yA", 64'(yA), 64'h0);
            chk("idle_yvA", 64'(yvA), 64'h0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
